// File: rtl/switch_fabric.sv
// rtl/switch_fabric.sv - input-queued packet switch with per-output round-robin arbiters and a slave status port
module switch_fabric #(
    parameter int NPORTS = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic                    read,
    input  logic [ADDR_W-1:0]       address,
    input  logic [WIDTH-1:0]        writedata,
    output logic [WIDTH-1:0]        readdata,
    output logic [NPORTS*WIDTH-1:0] out_data,
    output logic [NPORTS-1:0]       out_valid,
    input  logic [NPORTS-1:0]       out_ready
);
    localparam int DW = $clog2(NPORTS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);
    localparam logic [WIDTH-1:0] SAT  = '1;

    logic [WIDTH-1:0] mem    [NPORTS][DEPTH];
    logic [PW-1:0]    rd_ptr [NPORTS];
    logic [PW-1:0]    wr_ptr [NPORTS];
    logic [CW-1:0]    count  [NPORTS];
    logic [WIDTH-1:0] drop   [NPORTS];
    logic [DW-1:0]    rr_ptr [NPORTS];

    logic              wr_en, rd_en, in_q, in_d;
    logic [DW-1:0]     sel;
    logic [NPORTS-1:0] enq, clr, acc, rej;

    always_comb begin
        wr_en = chipselect && write;
        rd_en = chipselect && read;
        in_q  = int'(address) < NPORTS;
        in_d  = !in_q && (int'(address) < 2 * NPORTS);
        sel   = address[DW-1:0];
        for (int i = 0; i < NPORTS; i++) begin
            enq[i] = wr_en && in_q && (sel == DW'(i));
            clr[i] = wr_en && in_d && (sel == DW'(i));
            // full is judged on the occupancy at this edge; a same-cycle pop does not help
            acc[i] = enq[i] && (count[i] < FULL);
            rej[i] = enq[i] && !(count[i] < FULL);
        end
    end

    logic [WIDTH-1:0]  head [NPORTS];
    logic [DW-1:0]     dest [NPORTS];
    logic [NPORTS-1:0] has;

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            head[i] = mem[i][rd_ptr[i]];
            dest[i] = head[i][WIDTH-1 -: DW];
            has[i]  = count[i] != '0;
        end
    end

    logic [NPORTS-1:0] gnt_vld;
    logic [DW-1:0]     gnt_idx [NPORTS];
    logic [NPORTS-1:0] pop;

    always_comb begin
        logic [DW-1:0] idx;
        logic          stage_free;
        idx        = '0;
        stage_free = 1'b0;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            stage_free = !out_valid[o] || out_ready[o];
            // upward search from rr_ptr; DW-bit addition wraps modulo NPORTS
            for (int k = 0; k < NPORTS; k++) begin
                idx = rr_ptr[o] + DW'(k);
                if (stage_free && !gnt_vld[o] && has[idx] && (dest[idx] == DW'(o))) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = idx;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (gnt_vld[o]) begin
                pop[gnt_idx[o]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPORTS; i++) begin
            if (acc[i]) begin
                mem[i][wr_ptr[i]] <= writedata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPORTS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                drop[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (acc[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (acc[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!acc[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
                if (clr[i]) begin
                    drop[i] <= '0;
                end else if (rej[i] && (drop[i] != SAT)) begin
                    drop[i] <= drop[i] + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= '0;
            out_data  <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                rr_ptr[o] <= '0;
            end
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                if (gnt_vld[o]) begin
                    out_data[o*WIDTH +: WIDTH] <= head[gnt_idx[o]];
                    out_valid[o]               <= 1'b1;
                    rr_ptr[o]                  <= gnt_idx[o] + DW'(1);
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            if (in_q) begin
                readdata <= WIDTH'(count[sel]);
            end else if (in_d) begin
                readdata <= drop[sel];
            end else begin
                readdata <= '0;
            end
        end
    end
endmodule

// File: tb/tb_switch_fabric.sv
// tb/tb_switch_fabric.sv - scoreboard bench for switch_fabric: directed scenarios plus randomized traffic
module tb_switch_fabric;
    localparam int NP = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             chipselect;
    logic             write;
    logic             read;
    logic [AW-1:0]    address;
    logic [W-1:0]     writedata;
    logic [W-1:0]     readdata;
    logic [NP*W-1:0]  out_data;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_ready;

    switch_fabric #(.NPORTS(NP), .WIDTH(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit rand_mode = 1'b0;
    logic [W-1:0] exp_q [NP][$];
    logic [W-1:0] exp_k [NP][NP][$];
    int outstanding [NP];
    logic [NP-1:0] hold;
    logic [W-1:0]  hold_data [NP];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int s = 0; s < NP; s++) begin
            n += exp_q[s].size();
            for (int o = 0; o < NP; o++) n += exp_k[s][o].size();
        end
        return n;
    endfunction

    // monitor: compares every handshake with the scoreboard and checks stability under backpressure
    always @(negedge clk) begin
        logic [W-1:0] w;
        int src;
        if (!reset_n) begin
            hold = '0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                w = out_data[o*W +: W];
                if (hold[o]) begin
                    chk("hold_valid", 32'(out_valid[o]), 1);
                    chk("hold_data", 32'(w), 32'(hold_data[o]));
                end
                hold[o]      = out_valid[o] && !out_ready[o];
                hold_data[o] = w;
                if (out_valid[o] && out_ready[o]) begin
                    if (rand_mode) begin
                        src = int'(w[5:4]);
                        chk("dest_field", 32'(w[7:6]), 32'(o));
                        if (exp_k[src][o].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL rand_unexpected: port %0d got 0x%0h expected none", o, w);
                        end else begin
                            chk("rand_word", 32'(w), 32'(exp_k[src][o].pop_front()));
                            outstanding[src]--;
                        end
                    end else begin
                        if (exp_q[o].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL dir_unexpected: port %0d got 0x%0h expected none", o, w);
                        end else begin
                            chk("dir_word", 32'(w), 32'(exp_q[o].pop_front()));
                        end
                    end
                end
            end
        end
    end

    task automatic wr(input int a, input logic [W-1:0] d);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = AW'(a);
        writedata  = d;
        @(posedge clk); #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd(input int a, output logic [W-1:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = AW'(a);
        @(posedge clk); #1;
        chipselect = 1'b0;
        read       = 1'b0;
        d = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r;
        logic [W-1:0] w;
        int s, dd, guard;
        logic [3:0] seq;
        seq = '0;
        reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; out_ready = '0;
        for (int i = 0; i < NP; i++) outstanding[i] = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", out_data, 0);
        chk("rst_readdata", 32'(readdata), 0);
        for (int a = 0; a < 8; a++) begin
            rd(a, r);
            chk($sformatf("rst_rd%0d", a), 32'(r), 0);
        end

        // single word through output 1
        out_ready = '1;
        exp_q[1].push_back(8'h4A);
        wr(1, 8'h4A);
        chk("t2_not_yet", 32'(out_valid[1]), 0);
        idle(1);
        chk("t2_valid", 32'(out_valid[1]), 1);
        chk("t2_data", 32'(out_data[15:8]), 32'h4A);
        idle(1);
        chk("t2_one_cycle", 32'(out_valid[1]), 0);
        rd(1, r);
        chk("t2_occ", 32'(r), 0);

        // overflow FIFO 2 and clear its drop counter
        out_ready = '0;
        for (int k = 0; k < 5; k++) exp_q[2].push_back(8'h81 + 8'(k));
        for (int k = 0; k < 6; k++) wr(2, 8'h81 + 8'(k));
        chk("t3_stage_valid", 32'(out_valid[2]), 1);
        chk("t3_stage_data", 32'(out_data[23:16]), 32'h81);
        rd(2, r);
        chk("t3_occ", 32'(r), 4);
        rd(6, r);
        chk("t3_drop", 32'(r), 1);
        wr(6, 8'hFF);
        rd(6, r);
        chk("t3_drop_clr", 32'(r), 0);
        out_ready = 4'b0100;
        idle(8);
        out_ready = '0;
        chk("t3_drained", exp_q[2].size(), 0);
        rd(2, r);
        chk("t3_occ_empty", 32'(r), 0);

        // round robin on output 0
        exp_q[0].push_back(8'h01);
        exp_q[0].push_back(8'h02);
        exp_q[0].push_back(8'h03);
        wr(0, 8'h01); wr(1, 8'h02); wr(3, 8'h03);
        idle(2);
        out_ready[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rr_valid", 32'(out_valid[0]), 1);
            chk("rr_data", 32'(out_data[7:0]), 32'(k + 1));
        end
        @(negedge clk);
        chk("rr_empty", 32'(out_valid[0]), 0);
        @(posedge clk); #1;
        out_ready = '0;

        // backpressure on output 3
        exp_q[3].push_back(8'hC1);
        exp_q[3].push_back(8'hC2);
        wr(3, 8'hC1); wr(3, 8'hC2);
        idle(2);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid[3]), 1);
            chk("bp_hold_data", 32'(out_data[31:24]), 32'hC1);
        end
        @(posedge clk); #1;
        out_ready[3] = 1'b1;
        @(negedge clk);
        chk("bp_accept_data", 32'(out_data[31:24]), 32'hC1);
        @(negedge clk);
        chk("bp_next_valid", 32'(out_valid[3]), 1);
        chk("bp_next_data", 32'(out_data[31:24]), 32'hC2);
        @(negedge clk);
        chk("bp_empty", 32'(out_valid[3]), 0);
        @(posedge clk); #1;
        out_ready = '0;

        // drop counter saturation on FIFO 0
        for (int k = 0; k < 5; k++) exp_q[0].push_back(8'h11 + 8'(k));
        for (int k = 0; k < 305; k++) wr(0, (k < 5) ? 8'h11 + 8'(k) : 8'h3C);
        rd(4, r);
        chk("sat_drop", 32'(r), 32'hFF);
        rd(0, r);
        chk("sat_occ", 32'(r), 4);

        // asynchronous reset mid-cycle
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", out_data, 0);
        chk("arst_readdata", 32'(readdata), 0);
        for (int o = 0; o < NP; o++) exp_q[o].delete();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rd(0, r);
        chk("arst_occ", 32'(r), 0);
        rd(4, r);
        chk("arst_drop", 32'(r), 0);

        // randomized traffic, only writing where acceptance is guaranteed
        rand_mode = 1'b1;
        for (int n = 0; n < 600; n++) begin
            out_ready = 4'($urandom);
            s  = $urandom_range(0, NP - 1);
            dd = $urandom_range(0, NP - 1);
            if ($urandom_range(0, 9) < 7 && outstanding[s] < D) begin
                w = {2'(dd), 2'(s), seq};
                seq = seq + 4'd1;
                exp_k[s][dd].push_back(w);
                outstanding[s]++;
                wr(s, w);
            end else begin
                idle(1);
            end
        end
        out_ready = '1;
        guard = 0;
        while (pending() != 0 && guard < 200) begin
            idle(1);
            guard++;
        end
        chk("rand_drain", pending(), 0);
        idle(2);
        chk("rand_idle_valid", 32'(out_valid), 0);
        for (int a = 0; a < NP; a++) begin
            rd(a, r);
            chk($sformatf("end_occ%0d", a), 32'(r), 0);
            rd(NP + a, r);
            chk($sformatf("end_drop%0d", a), 32'(r), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/switch_fabric.md
# switch_fabric

Parametrised input-queued packet switch for the LED/VGA demo datapath. A host on the Avalon-style slave port enqueues WIDTH-bit words into one of NPORTS per-input FIFOs. Each word carries its destination output in its top bits. Per-output round-robin arbiters move head-of-line words into registered valid/ready output stages, and per-input occupancy and drop counters are readable over the same slave port.

## Interface
- NPORTS, 4: number of input queues and output ports; power of two, 2..8.
- WIDTH, 8: word width. The top log2(NPORTS) bits are the destination field.
- DEPTH, 4: entries per input FIFO; power of two, ≥2.
- ADDR_W, 3: slave address width; must satisfy 2^ADDR_W ≥ 2*NPORTS.

- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- chipselect  in  1  slave select.
- write  in  1  slave write strobe, qualified by chipselect.
- read  in  1  slave read strobe, qualified by chipselect.
- address  in  ADDR_W  register select.
- writedata  in  WIDTH  word to enqueue.
- readdata  out  WIDTH  status read result, registered.
- out_data  out  NPORTS*WIDTH  output o occupies slice [o*WIDTH +: WIDTH].
- out_valid  out  NPORTS  output o holds a word.
- out_ready  in  NPORTS  sink o accepts; transfer when out_valid[o] && out_ready[o].

## Operation
- Register map:
  - Write, addr i < NPORTS: enqueue writedata to FIFO i.
  - Write, addr NPORTS+i: clear drop counter i; writedata is ignored.
  - Read, addr i: occupancy of FIFO i, 0..DEPTH, zero-extended.
  - Read, addr NPORTS+i: drop counter i.
  - Other addresses: writes ignored, reads return 0.
- Enqueue accepted only if occupancy < DEPTH at that edge. A dequeue in the same cycle does not free space for the write.
- Rejected enqueue: word discarded; drop counter i increments and saturates at 2^WIDTH-1. If a clear and a drop hit the same counter in the same cycle, the clear wins (result 0).
- Head word of FIFO i requests output d = head[WIDTH-1 -: log2(NPORTS)]. Each input requests at most one output, so output arbiters are independent.
- Output stage o is "free" when !out_valid[o], or out_valid[o] && out_ready[o] this cycle.
- When stage o is free and at least one request for o exists, arbiter o grants the first requesting input at or after rr_ptr[o], searching upward modulo NPORTS.
- On a grant:
  - The granted FIFO pops.
  - The word, unmodified, loads into out_data[o], and out_valid[o] is set.
  - rr_ptr[o] becomes (grant+1) mod NPORTS.
- No grant: rr_ptr[o] is unchanged. out_valid[o] clears if the held word was taken; otherwise out_data/out_valid hold.
- While out_valid[o] && !out_ready[o], out_data[o] is stable.
- Simultaneous enqueue and dequeue on the same FIFO: occupancy unchanged. Pointers wrap modulo DEPTH.
- Enqueue into an empty FIFO is not bypassed to the output; the word must first become head.

## Timing
- Reset (reset_n low, asynchronous) clears:
  - all FIFOs to empty (occupancy 0);
  - rr_ptr to 0, drop counters to 0;
  - out_valid to 0, out_data to 0, readdata to 0.
- Reset mid-transfer discards all queued and held words immediately.
- Enqueue at edge t: occupancy reflects the word from t+1. The earliest out_valid for that word is edge t+1, visible cycle t+1→t+2.
- Zero-bubble throughput: with out_ready held high and a backlog, one word per cycle per output.
- Read issued at edge t: readdata is valid after edge t and holds until the next read. A read and a write in the same cycle returns the pre-write value.
- Pop-to-readback: a pop at edge t is reflected in the occupancy read sampled at t+1.

## Test plan
- Reset, then read addrs 0..7 → all return 0. out_valid=0000, out_data=0.
- Write 0x4A to addr 1 (dest 1) with out_ready=1111:
  - out_valid[1] rises one cycle after the write, with out_data[1]=0x4A, for exactly one cycle.
  - Occupancy of FIFO 1 reads 0 afterwards.
- Hold out_ready=0000 and write 6 words to addr 2 (DEPTH=4):
  - First word moves to the output stage; FIFO holds 4, so one word is dropped.
  - Addr 2 reads 4, addr 6 reads 1. A write to addr 6 clears it (reads 0).
- Round-robin: preload FIFOs 0, 1, 3 with dest-0 words 0x01, 0x02, 0x03, then raise out_ready[0]=1 → output 0 emits 0x01, 0x02, 0x03 on consecutive cycles.
- Backpressure: with out_valid[3]=1 and out_ready[3] toggling 0,0,1, out_data[3] holds constant until the accepting cycle, and the next queued word appears the following cycle.
- Saturation and async reset:
  - 300 rejected writes to a full FIFO 0 → addr 4 reads 0xFF.
  - Assert reset_n low mid-cycle → out_valid drops before the next clock edge.
